// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and constants for the UART transmit path:
//               controller state encoding, parity-mode encoding and the
//               width helper for the per-frame bit counter.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Controller states, explicitly encoded so waveforms read the same
    // across tools.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    // Value of the ParityOdd input that selects each parity sense.
    localparam logic C_PARITY_EVEN = 1'b0;
    localparam logic C_PARITY_ODD  = 1'b1;

    // Bits needed to count 0..data_bits-1 (never narrower than one bit).
    function automatic int bit_cnt_width(input int data_bits);
        return (data_bits > 1) ? $clog2(data_bits) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo
// Description : Synchronous TX FIFO. Power-of-two depth with free-running
//               pointers that wrap naturally; occupancy is held in a
//               separate counter so full and empty are unambiguous.
//               Pushes to a full FIFO and pops from an empty one are ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int                 C_AW    = $clog2(DEPTH);
    localparam int                 C_CW    = C_AW + 1;
    localparam logic [C_CW-1:0]    C_DEPTH = C_CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [C_AW-1:0]  r_wr_ptr;
    logic [C_AW-1:0]  r_rd_ptr;
    logic [C_CW-1:0]  r_count;

    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_full    = (r_count == C_DEPTH);
    assign o_empty   = (r_count == '0);
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];

    // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves
    // the occupancy unchanged.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + C_AW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + C_AW'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + C_CW'(1);
                2'b01:   r_count <= r_count - C_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array; contents need no reset because the pointers define
    // which entries are valid.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_xmit_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_xmit_fifo
// Description : FIFO-buffered UART transmitter. CPU writes land in a TX
//               FIFO; the controller pops one entry per frame and sends
//               start, DATA_BITS data bits LSB first, optional parity and
//               one or two stop bits, each lasting CLKS_PER_BIT clocks.
//               Every output is driven straight from a flop.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_xmit_fifo
    import uart_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                          Clock,
    input  logic                          Reset,
    input  logic                          WR,
    input  logic [31:0]                   Din,
    input  logic                          ParityEn,
    input  logic                          ParityOdd,
    input  logic                          TwoStop,
    output logic                          TxRDY,
    output logic                          TxD,
    output logic                          Busy,
    output logic [$clog2(FIFO_DEPTH):0]   Count,
    output logic                          Overrun
);

    localparam int                  C_CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [C_CNT_W-1:0]  C_DEPTH_CNT = C_CNT_W'(FIFO_DEPTH);
    localparam int                  C_DIV_W     = $clog2(CLKS_PER_BIT);
    localparam logic [C_DIV_W-1:0]  C_DIV_LAST  = C_DIV_W'(CLKS_PER_BIT - 1);
    localparam int                  C_BIT_W     = bit_cnt_width(DATA_BITS);
    localparam logic [C_BIT_W-1:0]  C_BIT_LAST  = C_BIT_W'(DATA_BITS - 1);

    // Controller state and per-frame datapath
    tx_state_t              r_state;
    logic [C_DIV_W-1:0]     r_div;
    logic [C_BIT_W-1:0]     r_bit;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_par_en;
    logic                   r_par_bit;
    logic                   r_two_stop;

    // Output flops
    logic                   r_txd;
    logic                   r_txrdy;
    logic                   r_busy;
    logic                   r_overrun;

    // Next-state values
    tx_state_t              w_state_next;
    logic [C_DIV_W-1:0]     w_div_next;
    logic [C_BIT_W-1:0]     w_bit_next;
    logic [DATA_BITS-1:0]   w_shift_next;
    logic                   w_txd_next;
    logic                   w_pop;
    logic                   w_wrap;

    // FIFO side
    logic [DATA_BITS-1:0]   w_fifo_dout;
    logic                   w_fifo_full;
    logic                   w_fifo_empty;
    logic                   w_push;
    logic [C_CNT_W-1:0]     w_count_next;

    // Bus bits above the character width are don't-care.
    logic                   w_unused_din;
    assign w_unused_din = ^Din[31:DATA_BITS];

    uart_tx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (Clock),
        .rst_n   (Reset),
        .i_push  (WR),
        .i_data  (Din[DATA_BITS-1:0]),
        .i_pop   (w_pop),
        .o_data  (w_fifo_dout),
        .o_count (Count),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign w_push = WR && !w_fifo_full;
    assign w_wrap = (r_div == C_DIV_LAST);

    // Occupancy after this edge, so TxRDY and Busy flip together with Count.
    always_comb begin
        w_count_next = Count;
        if (w_push && !w_pop) begin
            w_count_next = Count + C_CNT_W'(1);
        end else if (!w_push && w_pop) begin
            w_count_next = Count - C_CNT_W'(1);
        end
    end

    // Controller state register.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode; w_txd_next is the line level for the state being
    // entered so the registered TxD lines up with the state change.
    always_comb begin
        w_state_next = r_state;
        w_div_next   = r_div;
        w_bit_next   = r_bit;
        w_shift_next = r_shift;
        w_txd_next   = 1'b1;
        w_pop        = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = START;
                    w_div_next   = '0;
                    w_bit_next   = '0;
                    w_shift_next = w_fifo_dout;
                    w_txd_next   = 1'b0;
                end
            end
            START: begin
                if (w_wrap) begin
                    w_state_next = DATA;
                    w_div_next   = '0;
                    w_bit_next   = '0;
                    w_txd_next   = r_shift[0];
                end else begin
                    w_div_next   = r_div + C_DIV_W'(1);
                    w_txd_next   = 1'b0;
                end
            end
            DATA: begin
                w_txd_next = r_shift[0];
                if (w_wrap) begin
                    w_div_next   = '0;
                    w_shift_next = {1'b0, r_shift[DATA_BITS-1:1]};
                    if (r_bit == C_BIT_LAST) begin
                        w_bit_next = '0;
                        if (r_par_en) begin
                            w_state_next = PARITY;
                            w_txd_next   = r_par_bit;
                        end else begin
                            w_state_next = STOP;
                            w_txd_next   = 1'b1;
                        end
                    end else begin
                        w_bit_next = r_bit + C_BIT_W'(1);
                        w_txd_next = r_shift[1];
                    end
                end else begin
                    w_div_next = r_div + C_DIV_W'(1);
                end
            end
            PARITY: begin
                w_txd_next = r_par_bit;
                if (w_wrap) begin
                    w_state_next = STOP;
                    w_div_next   = '0;
                    w_bit_next   = '0;
                    w_txd_next   = 1'b1;
                end else begin
                    w_div_next = r_div + C_DIV_W'(1);
                end
            end
            STOP: begin
                w_txd_next = 1'b1;
                if (w_wrap) begin
                    w_div_next = '0;
                    // r_bit counts stop bits already completed.
                    if (r_two_stop && (r_bit == '0)) begin
                        w_bit_next = C_BIT_W'(1);
                    end else begin
                        w_state_next = IDLE;
                        w_bit_next   = '0;
                    end
                end else begin
                    w_div_next = r_div + C_DIV_W'(1);
                end
            end
            default: begin
                w_state_next = IDLE;
                w_div_next   = '0;
                w_bit_next   = '0;
            end
        endcase
    end

    // Divider, bit counter, shift register and the frame configuration,
    // which is captured only when an entry is popped.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_div      <= '0;
            r_bit      <= '0;
            r_shift    <= '0;
            r_par_en   <= 1'b0;
            r_par_bit  <= 1'b0;
            r_two_stop <= 1'b0;
        end else begin
            r_div   <= w_div_next;
            r_bit   <= w_bit_next;
            r_shift <= w_shift_next;
            if (w_pop) begin
                r_par_en   <= ParityEn;
                r_par_bit  <= (^w_fifo_dout) ^ (ParityOdd == C_PARITY_ODD);
                r_two_stop <= TwoStop;
            end
        end
    end

    // Registered outputs; Overrun is sticky until reset.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_txd     <= 1'b1;
            r_txrdy   <= 1'b1;
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_txd     <= w_txd_next;
            r_txrdy   <= (w_count_next != C_DEPTH_CNT);
            r_busy    <= (w_count_next != '0) || (w_state_next != IDLE);
            r_overrun <= r_overrun | (WR & w_fifo_full);
        end
    end

    assign TxD     = r_txd;
    assign TxRDY   = r_txrdy;
    assign Busy    = r_busy;
    assign Overrun = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_xmit_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_xmit_fifo
// Description : Self-checking bench for uart_xmit_fifo. A queue-based model
//               tracks the FIFO contents and the expected serial waveform
//               of the default instance; hand-computed frames pin the
//               model and exercise a 5-bit / 2-clock instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_xmit_fifo;

    localparam int C_CPB   = 4;
    localparam int C_DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic        wr, wr2;
    logic [31:0] din, din2;
    logic        par_en, par_odd, two_stop;

    logic        txrdy, txd, busy, overrun;
    logic [2:0]  count;
    logic        txrdy2, txd2, busy2, overrun2;
    logic [2:0]  count2;

    int n_checks = 0;
    int n_errors = 0;

    uart_xmit_fifo #(.DATA_BITS(8), .FIFO_DEPTH(C_DEPTH), .CLKS_PER_BIT(C_CPB)) u_dut (
        .Clock(clk), .Reset(rst_n), .WR(wr), .Din(din),
        .ParityEn(par_en), .ParityOdd(par_odd), .TwoStop(two_stop),
        .TxRDY(txrdy), .TxD(txd), .Busy(busy), .Count(count), .Overrun(overrun)
    );

    uart_xmit_fifo #(.DATA_BITS(5), .FIFO_DEPTH(4), .CLKS_PER_BIT(2)) u_dut5 (
        .Clock(clk), .Reset(rst_n), .WR(wr2), .Din(din2),
        .ParityEn(par_en), .ParityOdd(par_odd), .TwoStop(two_stop),
        .TxRDY(txrdy2), .TxD(txd2), .Busy(busy2), .Count(count2), .Overrun(overrun2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chkn(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model of the default instance ----------
    logic [7:0] mq[$];      // queued characters
    bit         ml[$];      // remaining per-clock line levels of the current frame
    bit         m_busyf;
    bit         m_valid;
    int         m_pre;
    logic [7:0] m_d;
    logic       e_txd, e_busy, e_rdy, e_ovr;
    int         e_cnt;

    task automatic mpush(input bit b, input int n);
        repeat (n) ml.push_back(b);
    endtask

    initial begin
        m_valid = 1'b0; m_busyf = 1'b0; e_ovr = 1'b0; e_txd = 1'b1;
        e_busy = 1'b0; e_rdy = 1'b1; e_cnt = 0;
        forever begin
            @(posedge clk);
            m_pre = mq.size();
            if (!rst_n) begin
                mq.delete();
                ml.delete();
                m_busyf = 1'b0;
                e_ovr   = 1'b0;
                e_txd   = 1'b1;
            end else begin
                if (m_busyf) begin
                    if (ml.size() > 0) begin
                        e_txd = ml.pop_front();
                    end else begin
                        e_txd   = 1'b1;
                        m_busyf = 1'b0;
                    end
                end else if (m_pre > 0) begin
                    m_d = mq.pop_front();
                    mpush(1'b0, C_CPB);
                    for (int i = 0; i < 8; i++) mpush(m_d[i], C_CPB);
                    if (par_en) mpush((^m_d) ^ par_odd, C_CPB);
                    mpush(1'b1, C_CPB);
                    if (two_stop) mpush(1'b1, C_CPB);
                    m_busyf = 1'b1;
                    e_txd   = ml.pop_front();
                end else begin
                    e_txd = 1'b1;
                end
                if (wr) begin
                    if (m_pre == C_DEPTH) e_ovr = 1'b1;
                    else mq.push_back(din[7:0]);
                end
            end
            e_cnt   = mq.size();
            e_rdy   = (mq.size() != C_DEPTH);
            e_busy  = m_busyf || (mq.size() != 0);
            m_valid = 1'b1;
        end
    end

    // Compare every cycle, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) begin
                chk1("cmp_txd", txd, e_txd);
                chk1("cmp_busy", busy, e_busy);
                chk1("cmp_txrdy", txrdy, e_rdy);
                chk1("cmp_overrun", overrun, e_ovr);
                chkn("cmp_count", 32'(count), 32'(e_cnt));
            end
        end
    end

    // ---------------- directed stimulus ----------------------------------
    // Writes one character and checks each bit mid-period against a
    // hand-computed frame (bit i of 'bits' is the i-th bit on the line).
    task automatic send_check(input bit use2, input logic [31:0] d, input logic [15:0] bits,
                              input int nbits, input int cpb, input string tag);
        int total;
        total = nbits * cpb;
        @(negedge clk);
        if (use2) begin wr2 = 1'b1; din2 = d; end
        else      begin wr  = 1'b1; din  = d; end
        @(negedge clk);
        wr = 1'b0; wr2 = 1'b0;
        for (int j = 1; j <= total + 1; j++) begin
            @(negedge clk);
            if (j <= total && ((j - 1) % cpb) == (cpb / 2 - 1)) begin
                chk1($sformatf("%s_bit%0d", tag, (j - 1) / cpb),
                     use2 ? txd2 : txd, bits[(j - 1) / cpb]);
            end
            if (j == total) chk1({tag, "_busy_last"}, use2 ? busy2 : busy, 1'b1);
            if (j == total + 1) begin
                chk1({tag, "_busy_end"}, use2 ? busy2 : busy, 1'b0);
                chk1({tag, "_txd_end"}, use2 ? txd2 : txd, 1'b1);
            end
        end
    endtask

    task automatic write1(input logic [31:0] d);
        @(negedge clk);
        wr = 1'b1; din = d;
    endtask

    task automatic wait_idle(input int max_cycles, input string tag);
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        chk1({tag, "_idle_within_bound"}, busy, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; wr = 1'b0; wr2 = 1'b0; din = '0; din2 = '0;
        par_en = 1'b0; par_odd = 1'b0; two_stop = 1'b0;
        repeat (3) @(negedge clk);
        chk1("rst_txd", txd, 1'b1);
        chk1("rst_txrdy", txrdy, 1'b1);
        chk1("rst_busy", busy, 1'b0);
        chkn("rst_count", 32'(count), 32'd0);
        chk1("rst_overrun", overrun, 1'b0);
        chk1("rst_txd5", txd2, 1'b1);
        chk1("rst_busy5", busy2, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Even parity, one stop; upper bus bits must be ignored.
        par_en = 1'b1; par_odd = 1'b0; two_stop = 1'b0;
        send_check(1'b0, 32'hABCDEF55, 16'h04AA, 11, C_CPB, "t1");

        // Odd parity, two stop bits, then no parity / one stop.
        par_odd = 1'b1; two_stop = 1'b1;
        send_check(1'b0, 32'h00000055, 16'h0EAA, 12, C_CPB, "t2");
        par_en = 1'b0; two_stop = 1'b0;
        send_check(1'b0, 32'h00000055, 16'h02AA, 10, C_CPB, "t2b");

        // Overflow: six back-to-back writes into a depth-4 FIFO.
        par_odd = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (i == 6) begin
                chkn("t3_count_full", 32'(count), 32'd4);
                chk1("t3_txrdy_full", txrdy, 1'b0);
                chk1("t3_no_overrun_yet", overrun, 1'b0);
            end
            wr = 1'b1; din = 32'(i);
        end
        @(negedge clk);
        wr = 1'b0;
        chk1("t3_overrun", overrun, 1'b1);
        chkn("t3_count_after_drop", 32'(count), 32'd4);
        wait_idle(400, "t3");

        // Configuration is latched per frame.
        par_en = 1'b0;
        write1(32'hA3);
        write1(32'h3C);
        @(negedge clk);
        wr = 1'b0;
        repeat (12) @(negedge clk);
        par_en = 1'b1;
        wait_idle(200, "t4");

        // Reset during data bit 3 of 0xF0 with two entries queued.
        par_en = 1'b0;
        write1(32'hF0);
        write1(32'h11);
        write1(32'h22);
        @(negedge clk);
        wr = 1'b0;
        chkn("t5_count_queued", 32'(count), 32'd2);
        repeat (16) @(negedge clk);
        chk1("t5_txd_bit3", txd, 1'b0);
        chk1("t5_overrun_before", overrun, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk1("t5_txd", txd, 1'b1);
        chkn("t5_count", 32'(count), 32'd0);
        chk1("t5_busy", busy, 1'b0);
        chk1("t5_overrun", overrun, 1'b0);
        repeat (50) @(negedge clk);
        chk1("t5_quiet_busy", busy, 1'b0);

        // 5 data bits, 2 clocks per bit, even parity.
        par_en = 1'b1; par_odd = 1'b0; two_stop = 1'b0;
        send_check(1'b1, 32'hFFFFFFF3, 16'h00E6, 8, 2, "t6");

        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/uart_xmit_fifo.md
Name: uart_xmit_fifo

Overview:
Parametrised next-generation UART transmitter for the 32-bit CPU's memory-mapped serial port. A CPU write strobe pushes the low DATA_BITS of the 32-bit bus into an internal TX FIFO. A single controller pops FIFO entries and serialises each into a frame:
- start bit
- DATA_BITS data bits, LSB first
- optional even or odd parity bit
- one or two stop bits

An internal divider paces each bit to CLKS_PER_BIT clocks, replacing the external bit clock used by the previous transmitter.

Parameters:
- DATA_BITS, 8, data bits per frame; legal range 5..9.
- FIFO_DEPTH, 4, TX FIFO entries; power of two, 2..16.
- CLKS_PER_BIT, 16, Clock cycles per serial bit; must be ≥ 2.

Ports:
- Clock  in  1  system clock; all logic on its rising edge.
- Reset  in  1  synchronous, active-low reset.
- WR  in  1  one-cycle write strobe; pushes Din[DATA_BITS-1:0].
- Din  in  32  CPU data bus; bits above DATA_BITS ignored.
- ParityEn  in  1  1 = parity bit present.
- ParityOdd  in  1  1 = odd parity, 0 = even; ignored when ParityEn = 0.
- TwoStop  in  1  1 = two stop bits, 0 = one.
- TxRDY  out  1  1 = FIFO not full; a write will be accepted.
- TxD  out  1  serial line; idles high.
- Busy  out  1  1 = FIFO non-empty or a frame in progress.
- Count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- Overrun  out  1  sticky: a write was dropped because the FIFO was full.

Behaviour:
- Reset (Reset = 0 at a rising edge):
  - Outputs: TxD = 1, TxRDY = 1, Busy = 0, Count = 0, Overrun = 0.
  - FIFO is flushed, state = IDLE, bit and divider counters = 0.
  - Reset mid-frame aborts the frame: TxD = 1 from the next edge, and the partial frame is never resumed.
- All outputs are registered.
- FIFO write:
  - WR = 1 and FIFO not full: the entry is written at that edge and Count increments.
  - WR = 1 and FIFO full: data is dropped and Overrun is set (sticky until reset).
  - Fullness is judged on the pre-edge state. A write to a full FIFO is dropped even if a pop occurs on the same edge.
  - Push and pop on the same edge leave Count unchanged.
- TxRDY = (Count != FIFO_DEPTH), from registered state.
- Controller state machine: IDLE, START, DATA, PARITY, STOP.
  - IDLE: TxD = 1. If the FIFO is non-empty, pop the head into the shift register and latch ParityEn, ParityOdd and TwoStop for the whole frame; go to START. Config changes mid-frame have no effect.
  - START: TxD = 0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: TxD = shift[0] for each bit, then shift right. After DATA_BITS bits go to PARITY if parity is enabled, else to STOP.
  - PARITY: TxD = XOR of the data bits, inverted if odd parity. Lasts one bit time, then go to STOP.
  - STOP: TxD = 1 for one bit time, or two bit times if TwoStop. Then go to IDLE.
- Divider: counts 0..CLKS_PER_BIT-1 and wraps. The state or bit advances on the wrap; the divider is cleared on entry to START.
- Back-to-back frames: IDLE lasts exactly one cycle between frames when the FIFO is non-empty, giving TxD = 1 for one extra clock.
- Latency:
  - WR accepted at edge k into an empty FIFO in IDLE: pop at edge k+1, TxD = 0 from edge k+1.
  - Frame length = (1 + DATA_BITS + ParityEn + 1 + TwoStop) × CLKS_PER_BIT cycles.
- Busy = (Count != 0) or (state != IDLE). Busy falls at the edge where STOP ends with the FIFO empty.
- Parity is computed on the DATA_BITS actually sent, not on Din.

Decomposition:
- Package uart_pkg:
  - tx_state_t enum: IDLE, START, DATA, PARITY, STOP.
  - Width helper for the bit counter.
  - Parity-mode constants.
- Sub-module uart_tx_fifo:
  - Parameters: width DATA_BITS, depth FIFO_DEPTH.
  - Ports: push, pop, data in/out, Count, full, empty.
  - Synchronous active-low reset.
  - Pointers are $clog2(FIFO_DEPTH) bits and wrap naturally.
- The controller, divider and shift register stay in uart_xmit_fifo.

Test Plan:
Benches use CLKS_PER_BIT = 4, DATA_BITS = 8, FIFO_DEPTH = 4 unless stated.
1. Even parity: ParityEn = 1, ParityOdd = 0, TwoStop = 0; write Din = 0x55 → TxD sequence per 4 clocks is 0, 1,0,1,0,1,0,1,0, 0, 1. That is 44 cycles; Busy = 0 afterwards.
2. Odd parity and two stop bits: ParityOdd = 1, TwoStop = 1; write 0x55 → parity bit = 1, stop high for 8 cycles, frame = 48 cycles. Repeat with ParityEn = 0 → 10-bit frame, 40 cycles.
3. Overflow: 6 WR pulses on consecutive edges (0x01..0x06) → 0x01 popped immediately, Count reaches 4, TxRDY = 0 after the 5th write. The 6th write is dropped and Overrun = 1. Exactly 0x01..0x05 are transmitted, each separated by one idle-high clock.
4. Config latch: start 0xA3 with ParityEn = 0, then set ParityEn = 1 during DATA → frame has no parity bit. The next queued frame includes parity.
5. Reset mid-frame: Reset = 0 for one edge during the DATA bit 3 of 0xF0 with 2 entries queued → TxD = 1, Count = 0, Busy = 0, Overrun = 0 next cycle. Nothing is transmitted until a new WR.
6. DATA_BITS = 5, CLKS_PER_BIT = 2: write Din = 0xFFFFFFF3 → data bits 1,1,0,0,1 are sent, and even parity = 1.
